// File: rtl/spectag_allocator_if.sv
// Dispatch/resolution bundle between the speculative-tag allocator and its neighbours.
// slave = allocator side, master = dispatch/fix-table side.
interface spectag_allocator_if #(
  parameter int unsigned NTAG = 5
);
  logic            req1;
  logic            req2;
  logic            dispatch_stall;
  logic            prsuccess;
  logic [NTAG-1:0] prsuccess_tag;
  logic            prmiss;
  logic [NTAG-1:0] prmiss_tag;
  logic [NTAG-1:0] prmiss_killmask;
  logic            setspec1_en;
  logic [NTAG-1:0] setspec1_tag;
  logic            setspec2_en;
  logic [NTAG-1:0] setspec2_tag;
  logic [NTAG-1:0] spectag1;
  logic [NTAG-1:0] spectag2;
  logic            alloc_stall;
  logic [2:0]      brdepth;
  logic [31:0]     stall_cnt;

  modport slave (
    input  req1, req2, dispatch_stall, prsuccess, prsuccess_tag,
           prmiss, prmiss_tag, prmiss_killmask,
    output setspec1_en, setspec1_tag, setspec2_en, setspec2_tag,
           spectag1, spectag2, alloc_stall, brdepth, stall_cnt
  );

  modport master (
    output req1, req2, dispatch_stall, prsuccess, prsuccess_tag,
           prmiss, prmiss_tag, prmiss_killmask,
    input  setspec1_en, setspec1_tag, setspec2_en, setspec2_tag,
           spectag1, spectag2, alloc_stall, brdepth, stall_cnt
  );
endinterface

// File: rtl/spectag_allocator.sv
// Ring-order one-hot speculative-tag allocator for up to two branches per cycle.
// Optional stall-cycle counter: define SPECTAG_STALL_CNT_EN.
module spectag_allocator #(
  parameter int unsigned NTAG = 5
) (
  input  logic             clk,
  input  logic             reset,
  spectag_allocator_if.slave bus
);
  localparam int unsigned DW = 3;

  logic [NTAG-1:0] free_mask_q, free_mask_d;
  logic [NTAG-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [NTAG-1:0] t1, t2, cur_tag;
  logic            stall_c, grant, en1, en2;
  logic [DW-1:0]   inflight;

  function automatic logic [NTAG-1:0] rotl1(input logic [NTAG-1:0] x);
    return {x[NTAG-2:0], x[NTAG-1]};
  endfunction

  function automatic logic [NTAG-1:0] rotr1(input logic [NTAG-1:0] x);
    return {x[0], x[NTAG-1:1]};
  endfunction

  // Candidate tags and pair-wise grant; a pair is granted whole or not at all
  always_comb begin
    cur_tag = rotr1(alloc_ptr_q);
    t1      = alloc_ptr_q;
    t2      = bus.req1 ? rotl1(alloc_ptr_q) : alloc_ptr_q;
    stall_c = (bus.req1 && ((free_mask_q & t1) == '0)) ||
              (bus.req2 && ((free_mask_q & t2) == '0));
    grant   = !stall_c && !bus.dispatch_stall && !bus.prmiss;
    en1     = bus.req1 && grant;
    en2     = bus.req2 && grant;
  end

  assign bus.alloc_stall  = stall_c;
  assign bus.setspec1_en  = en1;
  assign bus.setspec1_tag = t1;
  assign bus.setspec2_en  = en2;
  assign bus.setspec2_tag = t2;
  assign bus.spectag1     = bus.req1 ? t1 : cur_tag;
  assign bus.spectag2     = bus.req2 ? t2 : (bus.req1 ? t1 : cur_tag);

  // Next state; a miss overrides grants and redirects the ring pointer
  always_comb begin
    free_mask_d = free_mask_q;
    alloc_ptr_d = alloc_ptr_q;
    if (bus.prmiss) begin
      free_mask_d = free_mask_q | bus.prmiss_killmask;
      alloc_ptr_d = bus.prmiss_tag;
    end else begin
      if (en1) free_mask_d = free_mask_d & ~t1;
      if (en2) free_mask_d = free_mask_d & ~t2;
      if (en2)      alloc_ptr_d = rotl1(t2);
      else if (en1) alloc_ptr_d = rotl1(t1);
    end
    if (bus.prsuccess) free_mask_d = free_mask_d | bus.prsuccess_tag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_mask_q <= '1;
      alloc_ptr_q <= NTAG'(1);
    end else begin
      free_mask_q <= free_mask_d;
      alloc_ptr_q <= alloc_ptr_d;
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(NTAG); i++) inflight = inflight + DW'(!free_mask_q[i]);
  end

  assign bus.brdepth = inflight;

`ifdef SPECTAG_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles where dispatch was held for lack of tags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                               stall_cnt_q <= '0;
    else if (stall_c && !bus.prmiss && (stall_cnt_q != '1))   stall_cnt_q <= stall_cnt_q + 32'(1);
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_spectag_allocator.sv
// Scoreboard-driven bench for spectag_allocator: expectations queued at stimulus, popped at sample.
module tb_spectag_allocator;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] e;

  spectag_allocator_if #(.NTAG(5)) bus ();
  spectag_allocator #(.NTAG(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req1 = 1'b0; bus.req2 = 1'b0; bus.dispatch_stall = 1'b0;
    bus.prsuccess = 1'b0; bus.prsuccess_tag = '0;
    bus.prmiss = 1'b0; bus.prmiss_tag = '0; bus.prmiss_killmask = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    sb_q.push_back(32'd0); sb_q.push_back(32'd0);
    sb_q.push_back(32'b10000); sb_q.push_back(32'd0); sb_q.push_back(32'd0);
    tick(); #1;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.brdepth) !== e) begin errors++; $display("FAIL reset_brdepth got %0h exp %0h", bus.brdepth, e); end
    e = sb_q.pop_front(); checks++;
    if (bus.stall_cnt !== e) begin errors++; $display("FAIL reset_stall_cnt got %0h exp %0h", bus.stall_cnt, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.spectag1) !== e) begin errors++; $display("FAIL reset_cur_tag got %b exp %b", bus.spectag1, e[4:0]); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.alloc_stall) !== e) begin errors++; $display("FAIL reset_alloc_stall got %b exp %b", bus.alloc_stall, e[0]); end
    e = sb_q.pop_front(); checks++;
    if (32'({bus.setspec1_en, bus.setspec2_en}) !== e) begin errors++; $display("FAIL reset_enables got %b%b exp 00", bus.setspec1_en, bus.setspec2_en); end
  endtask

  task automatic test_pair();
    do_reset();
    bus.req1 = 1'b1; bus.req2 = 1'b1;
    sb_q.push_back(32'b00001); sb_q.push_back(32'b00010); sb_q.push_back(32'b11);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec1_tag) !== e) begin errors++; $display("FAIL pair_tag1 got %b exp %b", bus.setspec1_tag, e[4:0]); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec2_tag) !== e) begin errors++; $display("FAIL pair_tag2 got %b exp %b", bus.setspec2_tag, e[4:0]); end
    e = sb_q.pop_front(); checks++;
    if (32'({bus.setspec1_en, bus.setspec2_en}) !== e) begin errors++; $display("FAIL pair_enables got %b%b exp 11", bus.setspec1_en, bus.setspec2_en); end
    tick();
    bus.req1 = 1'b0; bus.req2 = 1'b0;
    sb_q.push_back(32'b00010); sb_q.push_back(32'd2);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.spectag1) !== e) begin errors++; $display("FAIL pair_cur_tag got %b exp %b", bus.spectag1, e[4:0]); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.brdepth) !== e) begin errors++; $display("FAIL pair_brdepth got %0d exp %0d", bus.brdepth, e); end
  endtask

  task automatic test_async_reset();
    // State is non-reset here; reset must act without waiting for an edge
    reset = 1'b0;
    sb_q.push_back(32'd0); sb_q.push_back(32'b10000);
    #1;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.brdepth) !== e) begin errors++; $display("FAIL async_brdepth got %0d exp %0d", bus.brdepth, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.spectag1) !== e) begin errors++; $display("FAIL async_cur_tag got %b exp %b", bus.spectag1, e[4:0]); end
  endtask

  task automatic test_ring_full();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.req1 = 1'b1;
      sb_q.push_back(32'(1) << i); sb_q.push_back(32'd1);
      #2;
      e = sb_q.pop_front(); checks++;
      if (32'(bus.setspec1_tag) !== e) begin errors++; $display("FAIL ring_tag%0d got %b exp %b", i, bus.setspec1_tag, e[4:0]); end
      e = sb_q.pop_front(); checks++;
      if (32'(bus.setspec1_en) !== e) begin errors++; $display("FAIL ring_en%0d got %b exp 1", i, bus.setspec1_en); end
      tick();
    end
    sb_q.push_back(32'd1); sb_q.push_back(32'd0); sb_q.push_back(32'd5);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.alloc_stall) !== e) begin errors++; $display("FAIL full_stall got %b exp %b", bus.alloc_stall, e[0]); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec1_en) !== e) begin errors++; $display("FAIL full_en got %b exp %b", bus.setspec1_en, e[0]); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.brdepth) !== e) begin errors++; $display("FAIL full_brdepth got %0d exp %0d", bus.brdepth, e); end
    for (int i = 0; i < 7; i++) tick();
`ifdef SPECTAG_STALL_CNT_EN
    sb_q.push_back(32'd7);
`else
    sb_q.push_back(32'd0);
`endif
    #2;
    e = sb_q.pop_front(); checks++;
    if (bus.stall_cnt !== e) begin errors++; $display("FAIL stall_cnt got %0d exp %0d", bus.stall_cnt, e); end
    // Tag freed this cycle must not be handed out until the next one
    bus.prsuccess = 1'b1; bus.prsuccess_tag = 5'b00001;
    sb_q.push_back(32'd1); sb_q.push_back(32'd0);
    #1;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.alloc_stall) !== e) begin errors++; $display("FAIL free_same_cycle_stall got %b exp 1", bus.alloc_stall); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec1_en) !== e) begin errors++; $display("FAIL free_same_cycle_en got %b exp 0", bus.setspec1_en); end
    tick();
    bus.prsuccess = 1'b0;
    sb_q.push_back(32'd1); sb_q.push_back(32'b00001);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec1_en) !== e) begin errors++; $display("FAIL wrap_en got %b exp 1", bus.setspec1_en); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec1_tag) !== e) begin errors++; $display("FAIL wrap_tag got %b exp %b", bus.setspec1_tag, e[4:0]); end
    tick();
    bus.req1 = 1'b0;
    sb_q.push_back(32'd5);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.brdepth) !== e) begin errors++; $display("FAIL wrap_brdepth got %0d exp %0d", bus.brdepth, e); end
  endtask

  task automatic test_miss();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req1 = 1'b1;
      tick();
    end
    // One free tag left: the pair must stall as a whole
    bus.req2 = 1'b1;
    sb_q.push_back(32'd1); sb_q.push_back(32'b00);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.alloc_stall) !== e) begin errors++; $display("FAIL pair_partial_stall got %b exp 1", bus.alloc_stall); end
    e = sb_q.pop_front(); checks++;
    if (32'({bus.setspec1_en, bus.setspec2_en}) !== e) begin errors++; $display("FAIL pair_partial_en got %b%b exp 00", bus.setspec1_en, bus.setspec2_en); end
    bus.req2 = 1'b0;
    bus.prmiss = 1'b1; bus.prmiss_tag = 5'b00100; bus.prmiss_killmask = 5'b01100;
    sb_q.push_back(32'd0);
    #1;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec1_en) !== e) begin errors++; $display("FAIL miss_no_grant got %b exp 0", bus.setspec1_en); end
    tick();
    bus.prmiss = 1'b0; bus.req1 = 1'b0;
    sb_q.push_back(32'd2); sb_q.push_back(32'b00010);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.brdepth) !== e) begin errors++; $display("FAIL miss_brdepth got %0d exp %0d", bus.brdepth, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.spectag1) !== e) begin errors++; $display("FAIL miss_cur_tag got %b exp %b", bus.spectag1, e[4:0]); end
    bus.req2 = 1'b1;
    sb_q.push_back(32'b00100); sb_q.push_back(32'b00010); sb_q.push_back(32'b01);
    #1;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec2_tag) !== e) begin errors++; $display("FAIL slot2_tag got %b exp %b", bus.setspec2_tag, e[4:0]); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.spectag1) !== e) begin errors++; $display("FAIL slot2_spectag1 got %b exp %b", bus.spectag1, e[4:0]); end
    e = sb_q.pop_front(); checks++;
    if (32'({bus.setspec1_en, bus.setspec2_en}) !== e) begin errors++; $display("FAIL slot2_en got %b%b exp 01", bus.setspec1_en, bus.setspec2_en); end
    bus.req2 = 1'b0; bus.req1 = 1'b1;
    sb_q.push_back(32'b00100);
    #1;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec1_tag) !== e) begin errors++; $display("FAIL miss_realloc_tag got %b exp %b", bus.setspec1_tag, e[4:0]); end
    tick();
    bus.dispatch_stall = 1'b1;
    sb_q.push_back(32'd0); sb_q.push_back(32'd0);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.alloc_stall) !== e) begin errors++; $display("FAIL dstall_alloc_stall got %b exp 0", bus.alloc_stall); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.setspec1_en) !== e) begin errors++; $display("FAIL dstall_en got %b exp 0", bus.setspec1_en); end
    tick();
    bus.dispatch_stall = 1'b0; bus.req1 = 1'b0;
    sb_q.push_back(32'd3);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.brdepth) !== e) begin errors++; $display("FAIL dstall_brdepth got %0d exp %0d", bus.brdepth, e); end
    // In flight: 00001,00010,00100. Miss on 00010 kills 00110, success frees 00001
    bus.prmiss = 1'b1; bus.prmiss_tag = 5'b00010; bus.prmiss_killmask = 5'b00110;
    bus.prsuccess = 1'b1; bus.prsuccess_tag = 5'b00001;
    tick();
    idle_inputs();
    sb_q.push_back(32'd0); sb_q.push_back(32'b00001);
    #2;
    e = sb_q.pop_front(); checks++;
    if (32'(bus.brdepth) !== e) begin errors++; $display("FAIL miss_success_brdepth got %0d exp %0d", bus.brdepth, e); end
    e = sb_q.pop_front(); checks++;
    if (32'(bus.spectag1) !== e) begin errors++; $display("FAIL miss_success_cur_tag got %b exp %b", bus.spectag1, e[4:0]); end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_pair();
    test_async_reset();
    test_ring_full();
    test_miss();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries exp 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
